// File: rtl/fpu_mul_sched_if.sv
`default_nettype none
// ============================================================================
// fpu_mul_sched_if : request / response / multiplier bundle of fpu_mul_sched
// Rev 1.0
// ============================================================================
interface fpu_mul_sched_if #(
  parameter int TAG_W = 4
);
  logic             flush;
  logic             req0_valid;
  logic             req0_ready;
  logic [63:0]      req0_srca;
  logic [63:0]      req0_srcb;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid;
  logic             req1_ready;
  logic [63:0]      req1_srca;
  logic [63:0]      req1_srcb;
  logic [TAG_W-1:0] req1_tag;
  logic             mul_enable;
  logic [63:0]      mul_srca;
  logic [63:0]      mul_srcb;
  logic [63:0]      mul_dst;
  logic             rsp0_valid;
  logic [63:0]      rsp0_data;
  logic [TAG_W-1:0] rsp0_tag;
  logic             rsp1_valid;
  logic [63:0]      rsp1_data;
  logic [TAG_W-1:0] rsp1_tag;
  logic             busy;

  modport slave (
    input  flush, req0_valid, req0_srca, req0_srcb, req0_tag,
           req1_valid, req1_srca, req1_srcb, req1_tag, mul_dst,
    output req0_ready, req1_ready, mul_enable, mul_srca, mul_srcb,
           rsp0_valid, rsp0_data, rsp0_tag, rsp1_valid, rsp1_data, rsp1_tag, busy
  );

  modport master (
    output flush, req0_valid, req0_srca, req0_srcb, req0_tag,
           req1_valid, req1_srca, req1_srcb, req1_tag, mul_dst,
    input  req0_ready, req1_ready, mul_enable, mul_srca, mul_srcb,
           rsp0_valid, rsp0_data, rsp0_tag, rsp1_valid, rsp1_data, rsp1_tag, busy
  );
endinterface
`default_nettype wire

// File: rtl/fpu_mul_sched.sv
`default_nettype none
// ============================================================================
// fpu_mul_sched : round-robin share of one double multiplier between FMUL
//                 issue (port 0) and the FDIV/FSQRT sequencer (port 1).
// Rev 1.0
// ============================================================================
module fpu_mul_sched #(
  parameter int MUL_LAT = 1,
  parameter int TAG_W   = 4
) (
  input  wire logic      clk,
  input  wire logic      reset,
  fpu_mul_sched_if.slave bus
);
  localparam int DEPTH = MUL_LAT + 1;

  logic                        gnt0;
  logic                        gnt1;
  logic                        accept;
  logic                        last_gnt_q, last_gnt_d;
  logic                        mul_en_q, mul_en_d;
  logic [63:0]                 mul_a_q, mul_a_d;
  logic [63:0]                 mul_b_q, mul_b_d;
  logic [DEPTH-1:0]            pipe_vld_q, pipe_vld_d;
  logic [DEPTH-1:0]            pipe_port_q, pipe_port_d;
  logic [DEPTH-1:0][TAG_W-1:0] pipe_tag_q, pipe_tag_d;
  logic                        tail_vld;
  logic                        rsp0_vld_q, rsp0_vld_d;
  logic                        rsp1_vld_q, rsp1_vld_d;
  logic [63:0]                 rsp0_data_q, rsp0_data_d;
  logic [63:0]                 rsp1_data_q, rsp1_data_d;
  logic [TAG_W-1:0]            rsp0_tag_q, rsp0_tag_d;
  logic [TAG_W-1:0]            rsp1_tag_q, rsp1_tag_d;

  // Under contention port 0 wins unless it was the most recent grant.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!bus.flush) begin
      if (bus.req0_valid && (!bus.req1_valid || last_gnt_q)) begin
        gnt0 = 1'b1;
      end else if (bus.req1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign accept = gnt0 | gnt1;

  always_comb begin
    last_gnt_d = last_gnt_q;
    mul_en_d   = accept;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    if (gnt0) begin
      last_gnt_d = 1'b0;
      mul_a_d    = bus.req0_srca;
      mul_b_d    = bus.req0_srcb;
    end else if (gnt1) begin
      last_gnt_d = 1'b1;
      mul_a_d    = bus.req1_srca;
      mul_b_d    = bus.req1_srcb;
    end
  end

  // Tag pipeline tracks the multiplier; flush kills every stage at once.
  always_comb begin
    pipe_vld_d  = (pipe_vld_q << 1) & {DEPTH{~bus.flush}};
    pipe_port_d = pipe_port_q << 1;
    pipe_tag_d  = pipe_tag_q << TAG_W;
    pipe_vld_d[0]  = accept;
    pipe_port_d[0] = gnt1;
    pipe_tag_d[0]  = gnt1 ? bus.req1_tag : bus.req0_tag;
  end

  always_comb begin
    tail_vld    = pipe_vld_q[DEPTH-1] & ~bus.flush;
    rsp0_vld_d  = tail_vld & ~pipe_port_q[DEPTH-1];
    rsp1_vld_d  = tail_vld & pipe_port_q[DEPTH-1];
    rsp0_data_d = rsp0_vld_d ? bus.mul_dst : rsp0_data_q;
    rsp1_data_d = rsp1_vld_d ? bus.mul_dst : rsp1_data_q;
    rsp0_tag_d  = rsp0_vld_d ? pipe_tag_q[DEPTH-1] : rsp0_tag_q;
    rsp1_tag_d  = rsp1_vld_d ? pipe_tag_q[DEPTH-1] : rsp1_tag_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt_q  <= 1'b1;
      mul_en_q    <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      pipe_vld_q  <= '0;
      pipe_port_q <= '0;
      pipe_tag_q  <= '0;
      rsp0_vld_q  <= 1'b0;
      rsp1_vld_q  <= 1'b0;
      rsp0_data_q <= '0;
      rsp1_data_q <= '0;
      rsp0_tag_q  <= '0;
      rsp1_tag_q  <= '0;
    end else begin
      last_gnt_q  <= last_gnt_d;
      mul_en_q    <= mul_en_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_port_q <= pipe_port_d;
      pipe_tag_q  <= pipe_tag_d;
      rsp0_vld_q  <= rsp0_vld_d;
      rsp1_vld_q  <= rsp1_vld_d;
      rsp0_data_q <= rsp0_data_d;
      rsp1_data_q <= rsp1_data_d;
      rsp0_tag_q  <= rsp0_tag_d;
      rsp1_tag_q  <= rsp1_tag_d;
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.mul_enable = mul_en_q;
  assign bus.mul_srca   = mul_a_q;
  assign bus.mul_srcb   = mul_b_q;
  assign bus.rsp0_valid = rsp0_vld_q;
  assign bus.rsp0_data  = rsp0_data_q;
  assign bus.rsp0_tag   = rsp0_tag_q;
  assign bus.rsp1_valid = rsp1_vld_q;
  assign bus.rsp1_data  = rsp1_data_q;
  assign bus.rsp1_tag   = rsp1_tag_q;
  assign bus.busy       = (|pipe_vld_q) | rsp0_vld_q | rsp1_vld_q;
endmodule
`default_nettype wire

// File: doc/fpu_mul_sched.md
Name: fpu_mul_sched

Overview:
- Shares one double-precision multiplier datapath (combinational core, registered in front) between two requesters.
- Port 0 is the FPU issue stage (FMUL). Port 1 is the FDIV/FSQRT Newton-iteration sequencer.
- Round-robin arbitration with a valid/ready handshake. Operands are registered toward the multiplier, and a tag pipeline routes each product back to its originating port.
- A pipeline flush discards in-flight results.

Parameters:
- MUL_LAT, 1, cycles from mul_srca/mul_srcb/mul_enable registered to mul_dst valid; legal range 0..7.
- TAG_W, 4, width of the requester-supplied tag echoed with each result.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- flush  input  1  discard all in-flight operations; blocks grants this cycle
- req0_valid  input  1  port 0 request
- req0_ready  output  1  port 0 grant (combinational)
- req0_srca  input  64  port 0 operand A, IEEE double
- req0_srcb  input  64  port 0 operand B
- req0_tag  input  TAG_W  port 0 tag
- req1_valid  input  1  port 1 request
- req1_ready  output  1  port 1 grant
- req1_srca  input  64  port 1 operand A
- req1_srcb  input  64  port 1 operand B
- req1_tag  input  TAG_W  port 1 tag
- mul_enable  output  1  operand-valid strobe to multiplier
- mul_srca  output  64  multiplier operand A
- mul_srcb  output  64  multiplier operand B
- mul_dst  input  64  multiplier result
- rsp0_valid  output  1  one-cycle result pulse, port 0
- rsp0_data  output  64  port 0 result
- rsp0_tag  output  TAG_W  port 0 tag echo
- rsp1_valid  output  1  one-cycle result pulse, port 1
- rsp1_data  output  64  port 1 result
- rsp1_tag  output  TAG_W  port 1 tag echo
- busy  output  1  any operation in flight

Behaviour:
- Reset (async, any cycle):
  - All pipeline valid bits cleared.
  - rsp0_valid = rsp1_valid = 0; rsp*_data = 0; rsp*_tag = 0.
  - mul_enable = 0; mul_srca = mul_srcb = 0; busy = 0.
  - Round-robin pointer last_gnt = 1, so port 0 wins the first contention.
  - Reset mid-operation drops every in-flight op; no rsp is ever produced for it.
- Arbitration (combinational, same cycle):
  - If flush = 1: both ready = 0.
  - Else if only one port is valid: that port gets ready = 1.
  - Else if both are valid: the port != last_gnt gets ready; the other gets ready = 0.
  - At most one ready per cycle.
  - last_gnt updates only on an accepted handshake (valid & ready).
  - Requesters must hold srca/srcb/tag stable while valid & !ready.
- Issue:
  - Handshake at cycle N registers mul_srca/mul_srcb at N+1, with mul_enable = 1 for exactly one cycle per accepted op.
  - With no handshake, mul_enable = 0 and mul_srca/mul_srcb hold their last value (no toggling).
- Tag pipeline:
  - Shift register of depth MUL_LAT+1. Each entry holds {valid, port id, tag}.
  - An entry enters at N+1 and reaches the tail at N+1+MUL_LAT, when mul_dst is sampled.
- Response:
  - At N+2+MUL_LAT: rspP_valid = 1 for one cycle; rspP_data = mul_dst sampled at N+1+MUL_LAT; rspP_tag = tag.
  - The non-addressed port's rsp_valid = 0, and its data/tag hold.
  - Default latency from handshake to rsp is 3 cycles.
- Throughput:
  - One op per cycle, with no bubbles between back-to-back grants.
  - No response backpressure; requesters must always accept rsp.
- flush:
  - Clears all tag-pipeline valid bits at the clock edge.
  - A response that would emerge in the flush cycle is suppressed.
  - The mul_* operand registers are not cleared; mul_enable is forced 0 the next cycle.
  - Simultaneous flush and request: the request is not accepted.
- busy = OR of all tag-pipeline valid bits, plus the pending rsp stage.
- Arithmetic: none performed here; results are passed through unmodified. Sign, exponent and saturation are entirely the multiplier's responsibility.

Test Plan:
- Single port-0 op: srca=0x3FF8000000000000 (1.5), srcb=0x4000000000000000 (2.0), tag=5 at cycle 0, multiplier model with MUL_LAT=1 -> mul_enable=1 at cycle 1; rsp0_valid=1 at cycle 3 with rsp0_data=0x4008000000000000, rsp0_tag=5; rsp1_valid stays 0.
- Contention: both ports valid continuously for 6 cycles after reset -> grants 0,1,0,1,0,1; responses alternate rsp0/rsp1 with the same ordering, 3 cycles later each, no gaps.
- Port 1 alone, back-to-back tags 1,2,3 -> ready=1 every cycle; rsp1 on 3 consecutive cycles with tags 1,2,3 in order.
- Flush with 2 ops in flight (issued cycles 0,1; flush at cycle 2 with req0_valid=1) -> req0_ready=0 at cycle 2; no rsp pulses on either port; busy=0 at cycle 3.
- Async reset asserted mid-cycle with 2 ops in flight -> all outputs zero immediately; no rsp after release; first contention after release grants port 0.
- MUL_LAT=3 build: single op -> rsp at handshake+5; busy high for exactly the in-flight window.
